alu_share_arbiter: RTL



---
 rtl/alu_share_arbiter_if.sv | 64 ++++++
 rtl/alu_share_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_share_pkg / alu_share_arbiter_if
// ALU operation encoding and the requester-side request/response bundle.
// Revision: 1.0
// ---------------------------------------------------------------------------

package alu_share_pkg;

  typedef enum logic [4:0] {
    C_ADD_U = 5'd0,
    C_ADD   = 5'd1,
    C_SUB_U = 5'd2,
    C_SUB   = 5'd3,
    C_AND   = 5'd4,
    C_OR    = 5'd5,
    C_XOR   = 5'd6,
    C_NOR   = 5'd7,
    C_SLT   = 5'd8,
    C_SLTU  = 5'd9,
    C_SLL   = 5'd10,
    C_SRL   = 5'd11,
    C_SRA   = 5'd12,
    C_MULT  = 5'd13,
    C_MUL_U = 5'd14,
    C_BEQ   = 5'd15,
    C_BNE   = 5'd16,
    C_BLEZ  = 5'd17,
    C_BGTZ  = 5'd18,
    C_BLTZ  = 5'd19,
    C_BGEZ  = 5'd20
  } alu_sel_t;

endpackage

interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);

  logic [1:0]                     req_valid;
  logic [1:0]                     req_ready;
  logic [2*WIDTH-1:0]             req_a;
  logic [2*WIDTH-1:0]             req_b;
  logic [9:0]                     req_shift;
  alu_share_pkg::alu_sel_t [1:0]  req_op;
  logic [1:0]                     rsp_valid;
  logic [1:0]                     rsp_ready;
  logic [WIDTH-1:0]               rsp_result;
  logic                           rsp_branch;

  // Requester side: both requesters share one bundle, bit/slice i per side.
  modport master (
    output req_valid, req_a, req_b, req_shift, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_branch
  );

  modport slave (
    input  req_valid, req_a, req_b, req_shift, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_branch
  );

endinterface

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Round-robin sharing of one combinational ALU between two requesters,
// with registered operands/results and architectural HI/LO registers.
// Revision: 1.0
// ---------------------------------------------------------------------------

module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  alu_share_arbiter_if.slave      bus,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [4:0]              alu_shift,
  output alu_sel_t                alu_opsel,
  input  wire logic [WIDTH-1:0]   alu_result,
  input  wire logic [WIDTH-1:0]   alu_result_hi,
  input  wire logic               alu_branch_taken,
  output logic [WIDTH-1:0]        hi_q,
  output logic [WIDTH-1:0]        lo_q,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic             r_last_grant;
  logic             r_owner;
  logic             w_grant;
  logic             w_accept;
  logic [1:0]       w_req_ready;
  logic [1:0]       w_rsp_valid;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [4:0]       r_shift;
  alu_sel_t         r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_branch;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [4:0]       w_sel_shift;
  alu_sel_t         w_sel_op;
  logic             w_is_mult;

  // Contest winner; a lone requester always wins, a tie goes to the side
  // that did not win last time.
  always_comb begin
    w_grant = 1'b0;
    case (bus.req_valid)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_last_grant;
      default: w_grant = 1'b0;
    endcase
  end

  assign w_sel_a     = w_grant ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
  assign w_sel_b     = w_grant ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
  assign w_sel_shift = w_grant ? bus.req_shift[9:5] : bus.req_shift[4:0];
  assign w_sel_op    = bus.req_op[w_grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 2'b00;
    w_rsp_valid  = 2'b00;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|bus.req_valid) begin
          w_req_ready[w_grant] = 1'b1;
          w_accept             = 1'b1;
          w_next_state         = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next_state = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid[r_owner] = 1'b1;
        if (bus.rsp_ready[r_owner]) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_is_mult = (r_op == C_MULT) || (r_op == C_MUL_U);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_shift      <= '0;
      r_op         <= C_ADD_U;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_result     <= '0;
      r_branch     <= 1'b0;
      r_hi         <= '0;
      r_lo         <= '0;
    end else begin
      if (w_accept) begin
        r_a          <= w_sel_a;
        r_b          <= w_sel_b;
        r_shift      <= w_sel_shift;
        r_op         <= w_sel_op;
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
      end
      // The ALU sees only registered operands, so its result is sampled once.
      if (r_state == S_EXEC) begin
        r_result <= alu_result;
        r_branch <= alu_branch_taken;
        if (w_is_mult) begin
          r_hi <= alu_result_hi;
          r_lo <= alu_result;
        end
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_result = r_result;
  assign bus.rsp_branch = r_branch;

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_shift = r_shift;
  assign alu_opsel = r_op;

  assign hi_q = r_hi;
  assign lo_q = r_lo;
  assign busy = (r_state != S_IDLE);

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.rsp_valid));
  a_idle_no_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_IDLE) |-> (bus.rsp_valid == 2'b00));

endmodule

`default_nettype wire
